// File: rtl/game_pkg.sv
// game_pkg: player-state codes, sprite width and CPU-opponent FSM encodings
// shared by both player controllers and the CPU opponent.
package game_pkg;
   localparam logic [3:0] IDLE = 4'd0, FORWARD = 4'd1, BACKWARD = 4'd2;
   localparam logic [3:0] IATTACK_START = 4'd3, IATTACK_ACTIVE = 4'd4, IATTACK_END = 4'd5;
   localparam logic [3:0] DATTACK_START = 4'd6, DATTACK_ACTIVE = 4'd7, DATTACK_END = 4'd8;
   localparam logic [3:0] HITSTUN = 4'd9, BLOCKSTUN = 4'd10;
   localparam logic [9:0] PLAYER_WIDTH = 10'd64;
   localparam logic [2:0] AI_THINK = 3'd0, AI_APPROACH = 3'd1, AI_RETREAT = 3'd2;
   localparam logic [2:0] AI_BLOCK = 3'd3, AI_ATTACK = 3'd4, AI_COOLDOWN = 3'd5;
   typedef struct packed {
      logic in_left;
      logic in_right;
      logic attack;
   } ai_req_t;
   function automatic logic is_free(input logic [3:0] s);
      return s == IDLE || s == FORWARD || s == BACKWARD;
   endfunction
endpackage

// File: rtl/cpu_opponent_p2_if.sv
// cpu_opponent_p2_if: game-state observations in, P2 input requests out.
interface cpu_opponent_p2_if;
   logic       enable;
   logic [9:0] player1_pos_x;
   logic [3:0] player1_state;
   logic [9:0] player_pos_x;
   logic [3:0] player_state;
   logic       in_left;
   logic       in_right;
   logic       attack;
   logic [2:0] ai_state;
   modport master (
      input  enable, player1_pos_x, player1_state, player_pos_x, player_state,
      output in_left, in_right, attack, ai_state
   );
   modport slave (
      output enable, player1_pos_x, player1_state, player_pos_x, player_state,
      input  in_left, in_right, attack, ai_state
   );
endinterface

// File: rtl/cpu_opponent_p2_lfsr16.sv
// lfsr16: 16-bit Galois LFSR (taps 16'hB400) advancing while enabled;
// a zero seed would lock up, so it is replaced by 1.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_60Hz,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] q
);
   localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
   always_ff @(posedge clk_60Hz or posedge reset)
      if (reset) q <= INIT;
      else if (enable) q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/cpu_opponent_p2.sv
// cpu_opponent_p2: CPU opponent that drives P2's left/right/attack requests
// from both players' positions and states.
module cpu_opponent_p2 #(
   parameter logic [9:0]  PLAYER_WIDTH    = 10'd64,
   parameter logic [9:0]  ATTACK_RANGE    = 10'd40,
   parameter logic [9:0]  BLOCK_RANGE     = 10'd80,
   parameter logic [3:0]  REACTION_FRAMES = 4'd4,
   parameter logic [4:0]  RETREAT_FRAMES  = 5'd8,
   parameter logic [4:0]  BLOCK_TIMEOUT   = 5'd20,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input logic               clk_60Hz,
   input logic               reset,
   cpu_opponent_p2_if.master bus
);
   import game_pkg::*;
   localparam logic [3:0] CNT_INIT = REACTION_FRAMES - 4'd1;
   logic [3:0]  rnd;
   logic [11:0] rnd_unused;
   logic [10:0] reach, gap;
   logic        threat, free, stunned, p1_busy, p1_recover, in_range;
   logic [2:0]  state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [4:0]  tmr, tmr_n;
   ai_req_t     req, req_n;
   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk_60Hz(clk_60Hz),
      .reset(reset),
      .enable(bus.enable),
      .q({rnd_unused, rnd})
   );
   // Gap saturates at 0 when the sprites overlap.
   assign reach      = {1'b0, bus.player1_pos_x} + {1'b0, PLAYER_WIDTH};
   assign gap        = ({1'b0, bus.player_pos_x} >= reach) ? {1'b0, bus.player_pos_x} - reach : 11'd0;
   assign in_range   = gap <= {1'b0, ATTACK_RANGE};
   assign threat     = (bus.player1_state == IATTACK_START || bus.player1_state == DATTACK_START) && gap <= {1'b0, BLOCK_RANGE};
   assign free       = is_free(bus.player_state);
   assign stunned    = bus.player_state == HITSTUN || bus.player_state == BLOCKSTUN;
   assign p1_busy    = bus.player1_state == IATTACK_START || bus.player1_state == IATTACK_ACTIVE
                    || bus.player1_state == DATTACK_START || bus.player1_state == DATTACK_ACTIVE;
   assign p1_recover = bus.player1_state == IATTACK_END || bus.player1_state == DATTACK_END;
   always_comb begin
      state_n = state;
      cnt_n   = CNT_INIT;
      case (state)
         AI_THINK:
            if (threat) state_n = AI_BLOCK;
            else if (cnt != 4'd0) cnt_n = cnt - 4'd1;
            else if (free) state_n = (rnd == 4'd0) ? AI_RETREAT : in_range ? AI_ATTACK : AI_APPROACH;
         AI_APPROACH: state_n = threat ? AI_BLOCK : (in_range || !free) ? AI_THINK : AI_APPROACH;
         AI_RETREAT:  state_n = threat ? AI_BLOCK : (stunned || tmr == 5'd0) ? AI_THINK : AI_RETREAT;
         AI_BLOCK:    state_n = (!p1_busy || tmr == 5'd0 || (stunned && p1_recover)) ? AI_THINK : AI_BLOCK;
         AI_ATTACK:   state_n = AI_COOLDOWN;
         AI_COOLDOWN: state_n = (bus.player_state == IDLE) ? AI_THINK : AI_COOLDOWN;
         default:     state_n = AI_THINK;
      endcase
      if (!bus.enable) begin
         state_n = AI_THINK;
         cnt_n   = CNT_INIT;
      end
      // The frame timer is shared by RETREAT and BLOCK and reloads on any state change.
      tmr_n = (state_n == state) ? tmr - 5'd1 : (state_n == AI_BLOCK) ? BLOCK_TIMEOUT - 5'd1 : RETREAT_FRAMES - 5'd1;
      req_n.in_left  = state_n == AI_APPROACH || (state_n == AI_ATTACK && rnd[0]);
      req_n.in_right = state_n == AI_RETREAT || state_n == AI_BLOCK;
      req_n.attack   = state_n == AI_ATTACK;
   end
   always_ff @(posedge clk_60Hz or posedge reset)
      if (reset) begin
         state <= AI_THINK;
         cnt   <= CNT_INIT;
         tmr   <= 5'd0;
         req   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         tmr   <= tmr_n;
         req   <= req_n;
      end
   assign bus.in_left  = req.in_left;
   assign bus.in_right = req.in_right;
   assign bus.attack   = req.attack;
   assign bus.ai_state = state;
endmodule
